// File: rtl/weight_csc_encoder_if.sv
// Weight-memory read port between the CSC encoder (master) and the weight store (slave).
// Read data returns one cycle after the strobe.
interface weight_csc_encoder_if #(
  parameter int NZ_MAX = 9,
  parameter int DATA_W = 8
);
  localparam int AW = $clog2(NZ_MAX);

  logic              o_rd_en;
  logic [AW-1:0]     o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;

  modport master (output o_rd_en, output o_rd_addr, input i_rd_data);
  modport slave  (input o_rd_en, input o_rd_addr, output i_rd_data);
endinterface

// File: rtl/weight_csc_encoder.sv
// Scans one dense R_LEN x K_LEN filter row-major and packs its nonzeros into value/row/col/pointer form.
// Fixed NZ_MAX+2 cycles from accepted start to finish pulse; start is ignored until back in IDLE.
module weight_csc_encoder #(
  parameter int R_LEN  = 3,
  parameter int K_LEN  = 3,
  parameter int DATA_W = 8,
  localparam int NZ_MAX = R_LEN * K_LEN,
  localparam int AW     = $clog2(NZ_MAX),
  localparam int CW     = AW + 1,
  localparam int RW     = $clog2(R_LEN) + 1,
  localparam int KW     = $clog2(K_LEN) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  weight_csc_encoder_if.master      rd,
  output logic                      o_busy,
  output logic                      o_finish,
  output logic [CW-1:0]             o_length,
  output logic [DATA_W-1:0]         o_val [0:NZ_MAX-1],
  output logic [RW-1:0]             o_r   [0:NZ_MAX-1],
  output logic [KW-1:0]             o_k   [0:NZ_MAX-1],
  output logic [CW-1:0]             o_ptr [0:R_LEN]
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] sr;
  logic [KW-1:0] sk;
  logic          cap_vld;
  logic [RW-1:0] cap_r;
  logic [KW-1:0] cap_k;
  logic [CW-1:0] cnt;
  logic          nz;
  logic [CW-1:0] cnt_nxt;
  logic          start_acc;

  assign rd.o_rd_en   = rd_en;
  assign rd.o_rd_addr = rd_addr;
  assign start_acc    = (state == S_IDLE) && i_start;
  assign nz           = |rd.i_rd_data;
  assign cnt_nxt      = cnt + CW'(nz);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    o_busy    = 1'b0;
    o_finish  = 1'b0;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_SCAN;
      S_SCAN: begin
        rd_en  = 1'b1;
        o_busy = 1'b1;
        if (rd_addr == AW'(NZ_MAX - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        o_finish  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue counters (sr, sk) run alongside the address; their one-cycle-delayed copy tags returning data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_addr  <= '0;
      sr       <= '0;
      sk       <= '0;
      cap_vld  <= 1'b0;
      cap_r    <= '0;
      cap_k    <= '0;
      cnt      <= '0;
      o_length <= '0;
      for (int i = 0; i < NZ_MAX; i++) begin
        o_val[i] <= '0;
        o_r[i]   <= '0;
        o_k[i]   <= '0;
      end
      for (int i = 0; i <= R_LEN; i++) o_ptr[i] <= '0;
    end else begin
      cap_vld <= rd_en;
      cap_r   <= sr;
      cap_k   <= sk;

      if (start_acc) begin
        rd_addr  <= '0;
        sr       <= '0;
        sk       <= '0;
        cnt      <= '0;
        o_length <= '0;
        for (int i = 0; i <= R_LEN; i++) o_ptr[i] <= '0;
      end else if (rd_en) begin
        if (rd_addr != AW'(NZ_MAX - 1)) rd_addr <= rd_addr + AW'(1);
        if (sk == KW'(K_LEN - 1)) begin
          sk <= '0;
          sr <= sr + RW'(1);
        end else begin
          sk <= sk + KW'(1);
        end
      end

      if (cap_vld) begin
        cnt <= cnt_nxt;
        for (int i = 0; i < NZ_MAX; i++) begin
          if (nz && (cnt == CW'(i))) begin
            o_val[i] <= rd.i_rd_data;
            o_r[i]   <= cap_r;
            o_k[i]   <= cap_k;
          end
        end
        // Row end: the next row's pointer includes this element when it is nonzero.
        if (cap_k == KW'(K_LEN - 1)) begin
          for (int i = 0; i < R_LEN; i++) begin
            if (cap_r == RW'(i)) o_ptr[i+1] <= cnt_nxt;
          end
        end
      end

      if (state == S_DRAIN) o_length <= cnt_nxt;
    end
  end

endmodule

// File: doc/weight_csc_encoder.md
# weight_csc_encoder

Streams one dense filter (`R_LEN` rows × `K_LEN` columns) out of weight memory and compresses it into the sparse row/column/pointer form consumed by the address-to-RF stage. It sits directly upstream of that stage. Its `o_r`, `o_k`, `o_ptr` and `o_length` outputs connect straight to that stage's `i_r`, `i_k`, `i_ptr` and `i_length` inputs. The weight values themselves go to the weight register file.

## Interface
Parameters:
- `R_LEN`, default 3: filter rows.
- `K_LEN`, default 3: filter columns.
- `DATA_W`, default 8: weight width, two's complement.
- `NZ_MAX`, derived, equal to `R_LEN*K_LEN`: maximum number of nonzeros.

Ports:
- `i_clk`, input, 1: the single clock. All registers are clocked on its rising edge.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_start`, input, 1: begin encoding one filter. Sampled only in IDLE.
- `o_rd_en`, output, 1: weight memory read strobe.
- `o_rd_addr`, output, `$clog2(NZ_MAX)`: row-major address, equal to `r*K_LEN + k`.
- `i_rd_data`, input, `DATA_W`: read data. It is valid exactly one cycle after the cycle in which `o_rd_en` was high.
- `o_busy`, output, 1: high in states SCAN and DRAIN.
- `o_finish`, output, 1: one-cycle pulse when the outputs become valid.
- `o_length`, output, `$clog2(NZ_MAX)+1`: number of nonzero weights.
- `o_val[0:NZ_MAX-1]`, output, `DATA_W`: nonzero weight values, in scan order.
- `o_r[0:NZ_MAX-1]`, output, `$clog2(R_LEN)+1`: row index of each nonzero.
- `o_k[0:NZ_MAX-1]`, output, `$clog2(K_LEN)+1`: column index of each nonzero.
- `o_ptr[0:R_LEN]`, output, `$clog2(NZ_MAX)+1`: `o_ptr[r]` is the index of the first nonzero in row r; `o_ptr[R_LEN]` equals `o_length`.

## Operation
- State machine: IDLE → SCAN → DRAIN → DONE → IDLE.
  - IDLE: `o_rd_en` is 0. When `i_start` is high, clear the nonzero count, `o_length` and `o_ptr`, then enter SCAN.
  - SCAN: issue one read per cycle at addresses 0, 1, …, `NZ_MAX-1` (row-major scan: row r, column k).
    - After issuing address `NZ_MAX-1`, enter DRAIN.
  - DRAIN: `o_rd_en` is 0. Process the data returned for the final address, then enter DONE.
  - DONE: assert `o_finish` for one cycle, then return to IDLE.
- Capture pipeline: in the cycle after each read, `i_rd_data` is evaluated together with a one-cycle-delayed copy of (r, k).
  - The delayed (r, k) pair is kept as counters. No divider is used.
  - If `i_rd_data != 0`, write `o_val[cnt] = data`, `o_r[cnt] = r` and `o_k[cnt] = k`, then increment `cnt`.
  - Zero detection covers every bit. Negative values such as 8'h80 count as nonzero.
- Pointer build:
  - `o_ptr[0]` is always 0.
  - When the captured element is the last column of row r (`k == K_LEN-1`), `o_ptr[r+1]` is set to the updated `cnt`, i.e. including this element if it is nonzero.
  - An all-zero row therefore repeats the previous pointer value.
- `o_length` is set to the final `cnt` in DRAIN.
- Retention: `o_val`, `o_r`, `o_k` and `o_ptr` hold their values from the `o_finish` pulse until the next accepted `i_start`.
  - Entries at index ≥ `o_length` are don't-care, but they must hold their previous contents. They are not required to be zero.
- `i_start` while `o_busy` or in DONE is ignored, with no restart and no side effect.

## Timing
- Let cycle 0 be the cycle in which `i_start` is sampled in IDLE.
  - `o_rd_en` is high during cycles 1 to `NZ_MAX`, with `o_rd_addr` equal to cycle − 1.
  - Data is captured in cycles 2 to `NZ_MAX+1`; DRAIN is cycle `NZ_MAX+1`.
  - `o_finish` is high in cycle `NZ_MAX+2`, and the outputs are valid in that same cycle.
  - The earliest `i_start` that can be accepted for the next filter is in cycle `NZ_MAX+3`.
- Fixed latency of `NZ_MAX+2` cycles from start to finish, independent of sparsity.
- Reset (asynchronous, any state including mid-scan): state goes to IDLE, and `o_busy`, `o_finish`, `o_rd_en`, `o_rd_addr`, `cnt`, `o_length`, all `o_ptr`, `o_val`, `o_r` and `o_k` go to 0.
  - The first `i_start` after reset is accepted on the first clock edge at which `i_rst` is low.
- A read issued before reset must not produce a capture after reset is released.

## Test plan
- Mixed filter, 3×3, weights `[0,5,0 ; 0,0,0 ; -2,0,7]`, start at cycle 0:
  - `o_finish` at cycle 11.
  - `o_length` = 3; `o_val` = {5, −2, 7}; `o_r` = {0, 2, 2}; `o_k` = {1, 0, 2}; `o_ptr` = {0, 1, 1, 3}.
- All-zero filter:
  - `o_length` = 0 and `o_ptr` = {0, 0, 0, 0}.
  - `o_finish` still arrives at cycle 11.
- All-nonzero filter, values 1 to 9:
  - `o_length` = 9; `o_r` = {0,0,0,1,1,1,2,2,2}; `o_k` = {0,1,2,0,1,2,0,1,2}; `o_ptr` = {0, 3, 6, 9}.
- Only weight is 8'h80 at address 8:
  - `o_length` = 1; `o_val[0]` = 8'h80; `o_r[0]` = 2; `o_k[0]` = 2; `o_ptr` = {0, 0, 0, 1}.
- `i_start` pulsed at cycles 4 and 11 during a scan:
  - Both are ignored. There is exactly one `o_finish`, at cycle 11, and the results are unchanged.
  - A new `i_start` at cycle 12 is accepted.
- `i_rst` asserted at cycle 5 mid-scan and released at cycle 6:
  - All outputs read 0 at cycle 6 and no `o_finish` appears.
  - A restart at cycle 7 produces a correct result with `o_finish` at cycle 18.
